// File: rtl/axis_reg_pipe.sv
// rtl/axis_reg_pipe.sv - AXI4-Stream register slice pipeline; optional counters via AXIS_REG_PIPE_STATS_EN
module axis_reg_pipe #(
  parameter int DATA_BITS = 512,
  parameter int STAGES    = 1,
  parameter int MODE      = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   stats_clr,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_stalls
);
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int PW        = DATA_BITS + KEEP_BITS + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  generate
    if (MODE == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = aclk ^ areset;
      assign m_axis_tvalid  = s_axis_tvalid;
      assign m_axis_tdata   = s_axis_tdata;
      assign m_axis_tkeep   = s_axis_tkeep;
      assign m_axis_tlast   = s_axis_tlast;
      assign s_axis_tready  = m_axis_tready;
    end else begin : g_chain
      // Index 0 is the slave port, index STAGES the master port; stage k sits between k and k+1.
      logic [STAGES:0] vld;
      logic [STAGES:0] rdy;
      logic [PW-1:0]   pl [0:STAGES];

      assign vld[0]        = s_axis_tvalid;
      assign pl[0]         = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
      assign s_axis_tready = rdy[0];
      assign rdy[STAGES]   = m_axis_tready;
      assign m_axis_tvalid = vld[STAGES];
      assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = pl[STAGES];

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (MODE == 1) begin : g_fwd
          logic          valid_q;
          logic [PW-1:0] data_q;
          logic          load;

          // The ready chain !v[k] | rdy[k+1] unrolled: any empty slot downstream, or the sink ready.
          assign rdy[k]     = m_axis_tready | ~(&vld[STAGES:k+1]);
          assign load       = vld[k] & rdy[k];
          assign vld[k+1]   = valid_q;
          assign pl[k+1]    = data_q;

          // Load on upstream handshake, otherwise empty out when downstream takes the beat
          always_ff @(posedge aclk) begin
            if (areset) begin
              valid_q <= 1'b0;
            end else if (load) begin
              valid_q <= 1'b1;
              data_q  <= pl[k];
            end else if (rdy[k+1]) begin
              valid_q <= 1'b0;
            end
          end
        end else begin : g_skid
          skid_state_t   state;
          logic          valid_q;
          logic          ready_q;
          logic [PW-1:0] main_q;
          logic [PW-1:0] skid_q;
          logic          accept;
          logic          drain;

          assign accept   = vld[k] & ready_q;
          assign drain    = valid_q & rdy[k+1];
          assign rdy[k]   = ready_q;
          assign vld[k+1] = valid_q;
          assign pl[k+1]  = main_q;

          // Skid FSM: main feeds downstream, skid catches the beat that arrives during a stall
          always_ff @(posedge aclk) begin
            if (areset) begin
              state   <= EMPTY;
              valid_q <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              case (state)
                EMPTY: begin
                  ready_q <= 1'b1;
                  if (accept) begin
                    main_q  <= pl[k];
                    valid_q <= 1'b1;
                    state   <= ONE;
                  end
                end
                ONE: begin
                  case ({drain, accept})
                    2'b10: begin
                      valid_q <= 1'b0;
                      ready_q <= 1'b1;
                      state   <= EMPTY;
                    end
                    2'b11: begin
                      main_q  <= pl[k];
                      ready_q <= 1'b1;
                    end
                    2'b01: begin
                      skid_q  <= pl[k];
                      ready_q <= 1'b0;
                      state   <= FULL;
                    end
                    default: ready_q <= 1'b1;
                  endcase
                end
                FULL: begin
                  if (drain) begin
                    main_q  <= skid_q;
                    ready_q <= 1'b1;
                    state   <= ONE;
                  end else begin
                    ready_q <= 1'b0;
                  end
                end
                default: begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b0;
                  state   <= EMPTY;
                end
              endcase
            end
          end
        end
      end
    end
  endgenerate

`ifdef AXIS_REG_PIPE_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] pkt_cnt;
  logic [31:0] stall_cnt;

  // Traffic counters at the master port; a clear overrides a same-cycle increment
  always_ff @(posedge aclk) begin
    if (areset || stats_clr) begin
      beat_cnt  <= 32'd0;
      pkt_cnt   <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt <= beat_cnt + 32'd1;
        if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_beats  = beat_cnt;
  assign stat_pkts   = pkt_cnt;
  assign stat_stalls = stall_cnt;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stat_beats       = 32'd0;
  assign stat_pkts        = 32'd0;
  assign stat_stalls      = 32'd0;
`endif

endmodule

// File: tb/tb_axis_reg_pipe.sv
// tb/tb_axis_reg_pipe.sv - self-checking bench for axis_reg_pipe in modes 0, 1 and 2
module tb_axis_reg_pipe;
`ifdef AXIS_REG_PIPE_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic        s2_v, s2_r, s2_l, m2_v, m2_r, m2_l, clr2;
  logic [31:0] s2_d, m2_d, b2, p2, st2;
  logic [3:0]  s2_k, m2_k;
  logic        s1_v, s1_r, s1_l, m1_v, m1_r, m1_l, clr1;
  logic [31:0] s1_d, m1_d, b1, p1, st1;
  logic [3:0]  s1_k, m1_k;
  logic        s0_v, s0_r, s0_l, m0_v, m0_r, m0_l, clr0;
  logic [31:0] s0_d, m0_d, b0, p0, st0;
  logic [3:0]  s0_k, m0_k;

  axis_reg_pipe #(.DATA_BITS(32), .STAGES(2), .MODE(2)) u2 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s2_v), .s_axis_tready(s2_r), .s_axis_tdata(s2_d), .s_axis_tkeep(s2_k), .s_axis_tlast(s2_l),
    .m_axis_tvalid(m2_v), .m_axis_tready(m2_r), .m_axis_tdata(m2_d), .m_axis_tkeep(m2_k), .m_axis_tlast(m2_l),
    .stats_clr(clr2), .stat_beats(b2), .stat_pkts(p2), .stat_stalls(st2));

  axis_reg_pipe #(.DATA_BITS(32), .STAGES(2), .MODE(1)) u1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s1_v), .s_axis_tready(s1_r), .s_axis_tdata(s1_d), .s_axis_tkeep(s1_k), .s_axis_tlast(s1_l),
    .m_axis_tvalid(m1_v), .m_axis_tready(m1_r), .m_axis_tdata(m1_d), .m_axis_tkeep(m1_k), .m_axis_tlast(m1_l),
    .stats_clr(clr1), .stat_beats(b1), .stat_pkts(p1), .stat_stalls(st1));

  axis_reg_pipe #(.DATA_BITS(32), .STAGES(1), .MODE(0)) u0 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s0_v), .s_axis_tready(s0_r), .s_axis_tdata(s0_d), .s_axis_tkeep(s0_k), .s_axis_tlast(s0_l),
    .m_axis_tvalid(m0_v), .m_axis_tready(m0_r), .m_axis_tdata(m0_d), .m_axis_tkeep(m0_k), .m_axis_tlast(m0_l),
    .stats_clr(clr0), .stat_beats(b0), .stat_pkts(p0), .stat_stalls(st0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboards: beats pushed on slave handshakes, popped and compared on master handshakes.
  logic [36:0] q2[$];
  logic [36:0] q1[$];
  logic [36:0] hold2, hold1;
  logic        stall2 = 1'b0, stall1 = 1'b0;
  logic        mon_en = 1'b0;
  int          mcnt2 = 0, mcnt1 = 0;

  always @(negedge aclk) begin
    if (mon_en) begin
      if (s2_v && s2_r) q2.push_back({s2_d, s2_k, s2_l});
      if (stall2) check("m2 stable while stalled", {m2_v, m2_d, m2_k, m2_l}, {1'b1, hold2});
      if (m2_v && m2_r) begin
        mcnt2++;
        check("m2 beat expected", q2.size() != 0, 1'b1);
        if (q2.size() != 0) check("m2 order", {m2_d, m2_k, m2_l}, q2.pop_front());
      end
      stall2 = m2_v && !m2_r;
      hold2  = {m2_d, m2_k, m2_l};
      if (s1_v && s1_r) q1.push_back({s1_d, s1_k, s1_l});
      if (stall1) check("m1 stable while stalled", {m1_v, m1_d, m1_k, m1_l}, {1'b1, hold1});
      if (m1_v && m1_r) begin
        mcnt1++;
        check("m1 beat expected", q1.size() != 0, 1'b1);
        if (q1.size() != 0) check("m1 order", {m1_d, m1_k, m1_l}, q1.pop_front());
      end
      stall1 = m1_v && !m1_r;
      hold1  = {m1_d, m1_k, m1_l};
    end else begin
      stall2 = 1'b0;
      stall1 = 1'b0;
    end
  end

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic [3:0]  sk;
    logic        sl;
    logic        mr;
    logic        exp_sr;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic [3:0]  exp_mk;
    logic        exp_ml;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base;
    int acc;
    logic h1, h2;

    tbl[0] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1};
    tbl[2] = '{1'b1, 32'h1234_5678, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'h3, 1'b0};
    tbl[3] = '{1'b0, 32'hA5A5_A5A5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5, 4'h0, 1'b1};
    tbl[4] = '{1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1};
    tbl[5] = '{1'b1, 32'h0000_0001, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 4'h1, 1'b0};

    areset = 1'b1;
    {s2_v, s2_d, s2_k, s2_l, m2_r, clr2} = '0;
    {s1_v, s1_d, s1_k, s1_l, m1_r, clr1} = '0;
    {s0_v, s0_d, s0_k, s0_l, m0_r, clr0} = '0;
    repeat (3) step();
    check("reset m2 tvalid", m2_v, 1'b0);
    check("reset m2 s tready", s2_r, 1'b0);
    check("reset m1 tvalid", m1_v, 1'b0);
    check("reset m2 stats", {b2, p2, st2}, 96'd0);
    areset = 1'b0;
    #1;
    check("m2 s tready low before first edge", s2_r, 1'b0);
    step();
    check("m2 s tready after release", s2_r, 1'b1);
    mon_en = 1'b1;

    // MODE 0 combinational pass-through vectors
    for (int i = 0; i < 6; i++) begin
      s0_v = tbl[i].sv; s0_d = tbl[i].sd; s0_k = tbl[i].sk; s0_l = tbl[i].sl; m0_r = tbl[i].mr;
      #1;
      check($sformatf("mode0 vec %0d", i), {s0_r, m0_v, m0_d, m0_k, m0_l},
            {tbl[i].exp_sr, tbl[i].exp_mv, tbl[i].exp_md, tbl[i].exp_mk, tbl[i].exp_ml});
      step();
    end

    // MODE 2 continuous streaming: latency 2, no bubbles
    m2_r = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s2_v = 1'b1; s2_d = 32'(i); s2_k = s2_d[3:0]; s2_l = (i % 4 == 3);
      step();
      if (i == 0) check("m2 first beat not early", {m2_v, s2_r}, 2'b01);
      else check("m2 continuous", {m2_v, s2_r, m2_d}, {1'b1, 1'b1, 32'(i - 1)});
    end
    s2_v = 1'b0;
    repeat (3) step();
    check("m2 continuous beats", mcnt2, 1000);
    check("m2 stat_beats 1000", b2, 32'(1000 * S));
    check("m2 stat_pkts 250", p2, 32'(250 * S));

    // MODE 2 back-pressure: 2 stages hold exactly 4 beats
    m2_r = 1'b0; acc = 0;
    s2_v = 1'b1; s2_d = 32'd2000; s2_k = 4'h5; s2_l = 1'b0;
    for (int c = 0; c < 8; c++) begin
      h2 = s2_r;
      step();
      if (h2) begin acc++; s2_d = s2_d + 32'd1; end
    end
    check("m2 bp accepted", acc, 4);
    check("m2 bp s tready low", {s2_r, m2_v}, 2'b01);
    s2_v = 1'b0; m2_r = 1'b1; base = mcnt2;
    repeat (6) step();
    check("m2 bp drained", mcnt2 - base, 4);

    // MODE 1 and MODE 2 random valid/ready on both sides
    h1 = 1'b0; h2 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!h1) begin s1_v = 1'($urandom % 2); s1_d = $urandom; s1_k = 4'($urandom); s1_l = 1'($urandom % 2); end
      if (!h2) begin s2_v = 1'($urandom % 2); s2_d = $urandom; s2_k = 4'($urandom); s2_l = 1'($urandom % 2); end
      m1_r = 1'($urandom % 2);
      m2_r = 1'($urandom % 2);
      #1;
      h1 = s1_v && !s1_r;
      h2 = s2_v && !s2_r;
      step();
    end
    s1_v = 1'b0; s2_v = 1'b0; m1_r = 1'b1; m2_r = 1'b1;
    repeat (10) step();
    check("m1 random drained", q1.size(), 0);
    check("m2 random drained", q2.size(), 0);
    check("m1 random beats seen", mcnt1 > 500, 1'b1);

    // Reset with 3 beats in flight
    m2_r = 1'b0;
    for (int j = 0; j < 3; j++) begin
      s2_v = 1'b1; s2_d = 32'(3000 + j); s2_k = 4'hC; s2_l = 1'b0;
      step();
    end
    s2_v = 1'b0;
    mon_en = 1'b0;
    areset = 1'b1;
    step();
    areset = 1'b0;
    check("mid reset m2 tvalid", {m2_v, s2_r, m1_v}, 3'b000);
    q2.delete(); q1.delete();
    mon_en = 1'b1;
    step();
    check("mid reset s tready back", s2_r, 1'b1);
    m2_r = 1'b1; base = mcnt2;
    for (int j = 0; j < 4; j++) begin
      s2_v = 1'b1; s2_d = 32'(3100 + j); s2_k = 4'h9; s2_l = (j == 3);
      step();
    end
    s2_v = 1'b0;
    repeat (3) step();
    check("post reset packet beats", mcnt2 - base, 4);
    check("post reset queue empty", q2.size(), 0);

    // Stats: 5 packets of 4 beats
    clr2 = 1'b1; step(); clr2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s2_v = 1'b1; s2_d = 32'(4000 + i); s2_k = 4'hF; s2_l = (i % 4 == 3);
      step();
    end
    s2_v = 1'b0;
    repeat (3) step();
    check("stats beats 20", b2, 32'(20 * S));
    check("stats pkts 5", p2, 32'(5 * S));
    check("stats stalls 0", st2, 32'd0);

    // Stall counting after a clear
    m2_r = 1'b0;
    s2_v = 1'b1; s2_d = 32'd5000; s2_k = 4'h1; s2_l = 1'b1;
    step();
    s2_v = 1'b0;
    for (int c = 0; c < 10 && !m2_v; c++) step();
    check("stats beat arrived", m2_v, 1'b1);
    clr2 = 1'b1; step(); clr2 = 1'b0;
    repeat (5) step();
    check("stats stalls 5", {b2, st2}, {32'd0, 32'(5 * S)});

    // Clear coincident with the final beat wins
    m2_r = 1'b1; clr2 = 1'b1;
    step();
    m2_r = 1'b0; clr2 = 1'b0;
    step();
    check("stats clr with beat", {b2, p2, st2}, 96'd0);

`ifdef AXIS_REG_PIPE_STATS_EN
    // Counter wrap from all-ones
    s2_v = 1'b1; s2_d = 32'd6000; s2_k = 4'h2; s2_l = 1'b1;
    step();
    s2_v = 1'b0;
    for (int c = 0; c < 10 && !m2_v; c++) step();
    force u2.beat_cnt = 32'hFFFF_FFFF;
    #1;
    release u2.beat_cnt;
    m2_r = 1'b1;
    step();
    m2_r = 1'b0;
    step();
    check("stats beat wrap", {b2, p2}, {32'd0, 32'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
